alu_regfile: RTL and testbench
==============================

# alu_regfile

Eight-entry, 16-bit register file with an NZCV status register and a pending-write scoreboard. It sits directly upstream of the ALU, driving its A and B operands. It is also the ALU's writeback target: it captures the low 16 bits of the ALU result and the N/Z/C/V flags. The scoreboard raises a stall when an operand's producer has issued but not yet written back.

## Interface

Parameters:
- NREGS, 8, number of architectural registers (power of two)
- AW, 3, register address width, log2(NREGS)
- WIDTH, 16, data width

Ports:
- clk, input, 1, single clock; all state updates on the rising edge
- rst_n, input, 1, asynchronous active-low reset
- ra_addr, input, AW, read address for operand A
- rb_addr, input, AW, read address for operand B
- rd_en, input, 1, operands are being consumed this cycle; qualifies stall
- ra_data, output, WIDTH, operand A to the ALU
- rb_data, output, WIDTH, operand B to the ALU
- stall, output, 1, operand not yet available; issue must hold
- iss_en, input, 1, an instruction with destination iss_addr issues this cycle
- iss_addr, input, AW, destination of the issuing instruction
- wr_en, input, 1, writeback valid
- wr_addr, input, AW, writeback destination
- wr_data, input, WIDTH+1, ALU result R; only bits [WIDTH-1:0] are stored
- flag_we, input, 1, update the status register
- flags_in, input, 4, {N,Z,C,V} from the ALU
- flags_out, output, 4, current {N,Z,C,V}
- pending, output, NREGS, scoreboard bit per register (debug/verification)

## Operation

- **Reset:** rst_n low asynchronously clears all registers to 0x0000, flags_out to 4'b0000, and pending to all-zero. Release is synchronous to clk.
- **R0:**
  - R0 always reads 0x0000.
  - Writes to R0 are discarded.
  - iss_en with iss_addr==0 never sets pending[0].
- **Reads:** combinational.
  - ra_data = 0 if ra_addr==0.
  - Otherwise, if wr_en && wr_addr==ra_addr (nonzero), ra_data = wr_data[WIDTH-1:0]. This is same-cycle write-through bypass.
  - Otherwise ra_data = regs[ra_addr].
  - rb_data follows identical rules.
- **Write:** on a clock edge with wr_en and wr_addr!=0, regs[wr_addr] <= wr_data[WIDTH-1:0]. wr_data[WIDTH], the carry-out bit, is ignored.
- **Flags:** on a clock edge with flag_we, flags_out <= flags_in. Otherwise the register holds. flag_we is independent of wr_en.
- **Scoreboard:** on each edge, for each register r != 0:
  - Clear: wr_en && wr_addr==r clears pending[r].
  - Set: iss_en && iss_addr==r sets pending[r].
  - Both in the same cycle for the same r: set wins. The newer instruction now owns r.
- **Stall:** combinational.
  - stall = rd_en && (hazA || hazB).
  - hazA = ra_addr!=0 && pending[ra_addr] && !(wr_en && wr_addr==ra_addr).
  - hazB is the same with rb_addr.
  - A register being written back this cycle is not a hazard, because the bypass supplies its value.
- **Issue while stalled:** iss_en asserted while stall=1 is a protocol error. The block still applies it as specified; it does not check for it.
- **Double issue:** iss_en to a register that is already pending keeps pending set. The first writeback clears it; tracking is single-bit, not a count.
- **Reset mid-operation:** in-flight pending bits are lost. The stale writebacks that follow are applied normally.

## Timing

- Read and bypass latency: 0 cycles (combinational from address, wr_* inputs, and state).
- Write visible through the register array: 1 cycle after the edge; visible through the bypass in the same cycle.
- Flags visible on flags_out 1 cycle after the flag_we edge. There is no flag bypass.
- pending and stall reflect an issue from the edge after iss_en is asserted.
- Outputs ra_data, rb_data and stall have no register stage. flags_out and pending come straight from flops.

## Test plan

- **Reset and R0:**
  - Stimulus: assert rst_n=0 mid-run, then release. Write R0=0xFFFF with flag_we=0.
  - Required: all reads return 0x0000, flags_out=0, pending=0. Reads of R0 return 0x0000 afterwards.
- **Write/read and bypass:**
  - Stimulus: write R3=0x1234 with wr_data=17'h1_1234, and in the same cycle read ra_addr=3.
  - Required: ra_data=0x1234 in that cycle (bypass), and 0x1234 from the array on the next cycle. The carry bit is not stored.
- **Flags:**
  - Stimulus: flag_we=1 with flags_in=4'b1011, then flag_we=0 with flags_in=4'b0100.
  - Required: flags_out=4'b1011 after the first edge and remains 4'b1011 after the second.
- **Hazard and release:**
  - Stimulus: iss_en to R5. Next cycle, rd_en=1 with rb_addr=5.
  - Required: stall=1 on that cycle. In the cycle where wr_en=1, wr_addr=5 and wr_data=0x00AA, stall=0 and rb_data=0x00AA. pending[5]=0 afterwards.
- **Simultaneous set/clear:**
  - Stimulus: in the same cycle, wr_en to R2 and iss_en to R2 (pending[2] was 1).
  - Required: pending[2] stays 1, R2 holds the written value, and reading R2 next cycle with rd_en=1 gives stall=1.
- **Independent hazards:**
  - Stimulus: pending on R1 only; read ra_addr=4, rb_addr=1 with rd_en=0, then with rd_en=1.
  - Required: stall=0, then stall=1. Repeating with ra_addr=rb_addr=0 gives stall=0.

Source files
------------

// File: rtl/alu_regfile.sv
// alu_regfile: 8x16 register file with NZCV flags, write-through bypass and pending-write scoreboard
module alu_regfile #(
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    input  logic             rd_en,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic             stall,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH:0]   wr_data,
    input  logic             flag_we,
    input  logic [3:0]       flags_in,
    output logic [3:0]       flags_out,
    output logic [NREGS-1:0] pending
);
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [3:0]       r_flags;
    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_one;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_pend_nxt;
    logic             w_wr_nz;
    logic             w_byp_a;
    logic             w_byp_b;
    logic             w_haz_a;
    logic             w_haz_b;
    logic             w_unused_carry;

    assign w_unused_carry = wr_data[WIDTH];
    assign w_wr_nz = wr_en && (wr_addr != '0);
    assign w_one = {{(NREGS-1){1'b0}}, 1'b1};
    assign w_set = iss_en ? (w_one << iss_addr) : '0;
    assign w_clr = wr_en ? (w_one << wr_addr) : '0;
    // set after clear so a same-cycle reissue keeps ownership; bit 0 never tracks
    assign w_pend_nxt = ((r_pend & ~w_clr) | w_set) & ~w_one;

    assign w_byp_a = w_wr_nz && (wr_addr == ra_addr);
    assign w_byp_b = w_wr_nz && (wr_addr == rb_addr);
    assign ra_data = (ra_addr == '0) ? '0 : w_byp_a ? wr_data[WIDTH-1:0] : r_regs[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : w_byp_b ? wr_data[WIDTH-1:0] : r_regs[rb_addr];

    assign w_haz_a = (ra_addr != '0) && r_pend[ra_addr] && !w_byp_a;
    assign w_haz_b = (rb_addr != '0) && r_pend[rb_addr] && !w_byp_b;
    assign stall = rd_en && (w_haz_a || w_haz_b);

    assign flags_out = r_flags;
    assign pending = r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_flags <= '0;
            r_pend <= '0;
        end else begin
            if (w_wr_nz) r_regs[wr_addr] <= wr_data[WIDTH-1:0];
            if (flag_we) r_flags <= flags_in;
            r_pend <= w_pend_nxt;
        end
    end
endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: directed vectors with hand-computed expectations for alu_regfile
module tb_alu_regfile;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  ra_addr = '0, rb_addr = '0, iss_addr = '0, wr_addr = '0;
    logic        rd_en = 1'b0, iss_en = 1'b0, wr_en = 1'b0, flag_we = 1'b0;
    logic [16:0] wr_data = '0;
    logic [3:0]  flags_in = '0;
    logic [15:0] ra_data, rb_data;
    logic        stall;
    logic [3:0]  flags_out;
    logic [7:0]  pending;
    int          n_chk = 0;
    int          n_err = 0;

    alu_regfile dut (
        .clk(clk), .rst_n(rst_n), .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_en(rd_en),
        .ra_data(ra_data), .rb_data(rb_data), .stall(stall), .iss_en(iss_en),
        .iss_addr(iss_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flag_we(flag_we), .flags_in(flags_in), .flags_out(flags_out), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        ra_addr = 3'd3; rb_addr = 3'd7;
        #1;
        check("rst_ra", ra_data, 0);
        check("rst_rb", rb_data, 0);
        check("rst_flags", flags_out, 0);
        check("rst_pend", pending, 0);
        // write R3 with carry bit set, bypass in same cycle
        wr_en = 1; wr_addr = 3'd3; wr_data = 17'h1_1234; rb_addr = 3'd3;
        #1;
        check("byp_ra", ra_data, 16'h1234);
        check("byp_rb", rb_data, 16'h1234);
        tick();
        wr_en = 0; wr_data = 17'h0_5555;
        #1;
        check("arr_ra", ra_data, 16'h1234);
        // flags
        flag_we = 1; flags_in = 4'b1011;
        tick();
        check("flags_set", flags_out, 4'b1011);
        flag_we = 0; flags_in = 4'b0100;
        tick();
        check("flags_hold", flags_out, 4'b1011);
        // R0 write discarded
        wr_en = 1; wr_addr = 3'd0; wr_data = 17'h0_FFFF; ra_addr = 3'd0;
        #1;
        check("r0_byp", ra_data, 0);
        tick();
        wr_en = 0;
        #1;
        check("r0_arr", ra_data, 0);
        check("r0_flags", flags_out, 4'b1011);
        // hazard on R5
        iss_en = 1; iss_addr = 3'd5; rd_en = 1; rb_addr = 3'd5; ra_addr = 3'd0;
        #1;
        check("iss_pre_stall", stall, 0);
        check("iss_pre_pend", pending, 0);
        tick();
        iss_en = 0;
        #1;
        check("haz_pend", pending, 8'h20);
        check("haz_stall", stall, 1);
        wr_en = 1; wr_addr = 3'd5; wr_data = 17'h0_00AA;
        #1;
        check("rel_stall", stall, 0);
        check("rel_rb", rb_data, 16'h00AA);
        tick();
        wr_en = 0;
        #1;
        check("rel_pend", pending, 0);
        check("rel_arr", rb_data, 16'h00AA);
        // issue to R0 never tracked
        iss_en = 1; iss_addr = 3'd0;
        tick();
        iss_en = 0;
        check("iss_r0", pending, 0);
        // simultaneous set/clear on R2
        rd_en = 0; iss_en = 1; iss_addr = 3'd2;
        tick();
        check("r2_pend", pending, 8'h04);
        wr_en = 1; wr_addr = 3'd2; wr_data = 17'h1_0BEE;
        tick();
        wr_en = 0; iss_en = 0; ra_addr = 3'd2; rb_addr = 3'd0; rd_en = 1;
        #1;
        check("sc_pend", pending, 8'h04);
        check("sc_data", ra_data, 16'h0BEE);
        check("sc_stall", stall, 1);
        rd_en = 0; wr_en = 1; wr_addr = 3'd2; wr_data = 17'h0_0BEE;
        tick();
        wr_en = 0;
        check("sc_clr", pending, 0);
        // independent hazards with R1 pending
        iss_en = 1; iss_addr = 3'd1;
        tick();
        iss_en = 0; ra_addr = 3'd4; rb_addr = 3'd1; rd_en = 0;
        #1;
        check("ind_rd0", stall, 0);
        rd_en = 1;
        #1;
        check("ind_hazb", stall, 1);
        ra_addr = 3'd1; rb_addr = 3'd4;
        #1;
        check("ind_haza", stall, 1);
        ra_addr = 3'd0; rb_addr = 3'd0;
        #1;
        check("ind_r0", stall, 0);
        rd_en = 0;
        // double issue: single bit, first writeback clears
        iss_en = 1; iss_addr = 3'd1;
        tick();
        iss_en = 0;
        check("dbl_pend", pending, 8'h02);
        wr_en = 1; wr_addr = 3'd1; wr_data = 17'h0_0011;
        tick();
        wr_en = 0;
        check("dbl_clr", pending, 0);
        // mid-run reset drops pending; stale writeback still lands
        iss_en = 1; iss_addr = 3'd6;
        tick();
        iss_en = 0;
        check("mid_pend", pending, 8'h40);
        ra_addr = 3'd3; rb_addr = 3'd5;
        rst_n = 0;
        #1;
        check("mid_rst_pend", pending, 0);
        check("mid_rst_flags", flags_out, 0);
        check("mid_rst_ra", ra_data, 0);
        check("mid_rst_rb", rb_data, 0);
        tick();
        #3 rst_n = 1;
        wr_en = 1; wr_addr = 3'd6; wr_data = 17'h0_0066;
        tick();
        wr_en = 0; ra_addr = 3'd6; rd_en = 1;
        #1;
        check("stale_wr", ra_data, 16'h0066);
        check("stale_pend", pending, 0);
        check("stale_stall", stall, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end
endmodule
